// File: rtl/grant_decoder_38_pkg.sv
// Shared types and sizing helpers for the grant decoder.
package grant_decoder_38_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Width of a field holding 0..n-1; never narrower than one bit.
    function automatic int code_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter holding 0..n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/grant_decoder_38_onehot_decode.sv
// Combinational index -> one-hot decode with an in-range flag.
module onehot_decode #(
    parameter int N_OUT  = 8,
    parameter int CODE_W = 3
) (
    input  logic [CODE_W-1:0] code,
    output logic [N_OUT-1:0]  onehot,
    output logic              in_range
);

    assign in_range = (32'(code) < N_OUT);

    for (genvar i = 0; i < N_OUT; i++) begin : g_bit
        assign onehot[i] = (32'(code) == i);
    end

endmodule

// File: rtl/grant_decoder_38.sv
// Accepts an encoded requester index and holds a registered one-hot grant
// until ack or timeout, then idles for GAP cycles before the next code.
module grant_decoder_38
    import grant_decoder_38_pkg::*;
#(
    parameter  int N_OUT   = 8,
    parameter  int TIMEOUT = 16,
    parameter  int GAP     = 1,
    localparam int CODE_W  = code_w(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    output logic [N_OUT-1:0]  grant,
    output logic              grant_valid,
    input  logic              grant_ack,
    output logic              timeout_pulse,
    output logic              code_err
);

    localparam int HOLD_W = cnt_w(TIMEOUT);
    localparam int GAP_W  = cnt_w(GAP);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [N_OUT-1:0]   dec_onehot;
    logic               dec_in_range;

    onehot_decode #(
        .N_OUT  (N_OUT),
        .CODE_W (CODE_W)
    ) u_dec (
        .code     (in_code),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    // Gated with rst_n so ready drops the instant reset asserts.
    assign in_ready = (state == ST_IDLE) && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            grant         <= '0;
            grant_valid   <= 1'b0;
            timeout_pulse <= 1'b0;
            code_err      <= 1'b0;
            hold_cnt      <= '0;
            gap_cnt       <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            code_err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (dec_in_range) begin
                            grant       <= dec_onehot;
                            grant_valid <= 1'b1;
                            hold_cnt    <= '0;
                            state       <= ST_GRANT;
                        end else begin
                            code_err <= 1'b1;
                        end
                    end
                end
                ST_GRANT: begin
                    // Ack takes priority over an expiring hold counter.
                    if (grant_ack || hold_cnt == HOLD_LAST) begin
                        timeout_pulse <= !grant_ack;
                        grant         <= '0;
                        grant_valid   <= 1'b0;
                        hold_cnt      <= '0;
                        gap_cnt       <= '0;
                        state         <= (GAP > 0) ? ST_GAP : ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
